// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator processor controller:
// opcodes, 4-bit FSM state codes and Asel mux codes.
package acc_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned ASEL_W  = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_IN    = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [STATE_W-1:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [ASEL_W-1:0] ASEL_ALU = 2'b00;
    localparam logic [ASEL_W-1:0] ASEL_IN  = 2'b01;
    localparam logic [ASEL_W-1:0] ASEL_MEM = 2'b10;

    // Execute state reached from DECODE for a given opcode.
    function automatic state_t exec_state(input opcode_t op);
        state_t s;
        case (op)
            OP_LOAD:  s = S_LOAD;
            OP_STORE: s = S_STORE;
            OP_ADD:   s = S_ADD;
            OP_SUB:   s = S_SUB;
            OP_IN:    s = S_INPUT;
            OP_JZ:    s = S_JZ;
            OP_JPOS:  s = S_JPOS;
            default:  s = S_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/acc_decoder.sv
// Moore output decode: maps the controller state (plus the IN handshake
// strobe) onto memory address/strobe and Aregister datapath controls.
module acc_decoder
    import acc_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [STATE_W-1:0] state,
    input  logic [AW-1:0]      pc,
    input  logic [AW-1:0]      operand,
    input  logic               enter,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_we,
    output logic [ASEL_W-1:0]  asel,
    output logic               aload,
    output logic               sub,
    output logic               outen,
    output logic               halt
);

    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        asel     = ASEL_ALU;
        aload    = 1'b0;
        sub      = 1'b0;
        outen    = 1'b0;
        halt     = 1'b0;
        case (state_t'(state))
            S_FETCH:         mem_addr = pc;
            S_DECODE,
            S_JZ,
            S_JPOS:          mem_addr = operand;
            S_LOAD: begin
                mem_addr = operand;
                asel     = ASEL_MEM;
                aload    = 1'b1;
            end
            S_STORE: begin
                mem_addr = operand;
                mem_we   = 1'b1;
            end
            S_ADD: begin
                mem_addr = operand;
                aload    = 1'b1;
            end
            S_SUB: begin
                mem_addr = operand;
                sub      = 1'b1;
                aload    = 1'b1;
            end
            // The operator sees A on Output while the new value is keyed in.
            S_INPUT: begin
                asel  = ASEL_IN;
                outen = 1'b1;
                aload = enter;
            end
            S_HALT: begin
                outen = 1'b1;
                halt  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_controller.sv
// Control unit of the 8-bit accumulator processor: fetch/decode/execute FSM,
// PC and IR. Optional single-step gating of FETCH under ACC_CTRL_STEP_EN.
module acc_controller
    import acc_pkg::*;
#(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter,
    input  logic              step,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              Aeq0,
    input  logic              Apos,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [ASEL_W-1:0] Asel,
    output logic              Aload,
    output logic              Sub,
    output logic              Outen,
    output logic              halt,
    output logic [AW-1:0]     pc
);

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] ir;
    logic [AW-1:0] operand;
    opcode_t       opcode;
    logic          fetch_go;

    assign operand = ir[AW-1:0];
    assign opcode  = opcode_t'(ir[DW-1 -: OP_W]);

`ifdef ACC_CTRL_STEP_EN
    assign fetch_go = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign fetch_go    = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_START;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_START:  state_next = S_FETCH;
            S_FETCH:  if (fetch_go) state_next = S_DECODE;
            S_DECODE: state_next = exec_state(opcode);
            S_LOAD,
            S_STORE,
            S_ADD,
            S_SUB,
            S_JZ,
            S_JPOS:   state_next = S_FETCH;
            S_INPUT:  if (enter) state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_START;
        endcase
    end

    // PC/IR: fetch advances PC (wrapping silently); jumps overwrite it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            ir <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_go) begin
                        ir <= mem_rdata;
                        pc <= pc + AW'(1);
                    end
                end
                S_JZ:    if (Aeq0) pc <= operand;
                S_JPOS:  if (Apos) pc <= operand;
                default: ;
            endcase
        end
    end

    acc_decoder #(
        .AW(AW)
    ) u_decoder (
        .state    (state),
        .pc       (pc),
        .operand  (operand),
        .enter    (enter),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .asel     (Asel),
        .aload    (Aload),
        .sub      (Sub),
        .outen    (Outen),
        .halt     (halt)
    );

endmodule

// File: tb/tb_acc_controller.sv
// Bench for acc_controller: memory and Aregister environment, directed
// scenarios and random programs checked against an instruction-level model.
module tb_acc_controller;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned MEM_N = 32;

    logic          clk;
    logic          reset;
    logic          enter;
    logic          step;
    logic [DW-1:0] mem_rdata;
    logic          Aeq0;
    logic          Apos;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [1:0]    Asel;
    logic          Aload;
    logic          Sub;
    logic          Outen;
    logic          halt;
    logic [AW-1:0] pc;

    logic [DW-1:0] mem [MEM_N];
    logic [DW-1:0] a_reg;
    logic [DW-1:0] in_val;
    logic          flag_force;
    logic          force_eq0;
    logic          force_pos;
    int            n_checks;
    int            n_errors;
    int            we_count;

    logic [DW-1:0] ref_mem [MEM_N];
    logic [DW-1:0] ref_a;
    logic [AW-1:0] ref_pc;

    acc_controller #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enter     (enter),
        .step      (step),
        .mem_rdata (mem_rdata),
        .Aeq0      (Aeq0),
        .Apos      (Apos),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .Asel      (Asel),
        .Aload     (Aload),
        .Sub       (Sub),
        .Outen     (Outen),
        .halt      (halt),
        .pc        (pc)
    );

    assign mem_rdata = mem[mem_addr];
    assign Aeq0      = flag_force ? force_eq0 : (a_reg == 8'd0);
    assign Apos      = flag_force ? force_pos : (!a_reg[DW-1] && a_reg != 8'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ctrl_word();
        return 32'({mem_addr, mem_we, Asel, Aload, Sub, Outen, halt});
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: datapath/memory react to the pre-edge controls, as the real Aregister would.
    task automatic tick();
        logic [DW-1:0] m;
        logic [DW-1:0] a_next;
        logic [DW-1:0] a_old;
        logic          we;
        logic [AW-1:0] wa;
        #1;
        m      = mem[mem_addr];
        a_old  = a_reg;
        a_next = a_reg;
        if (Aload) begin
            case (Asel)
                2'b00:   a_next = Sub ? a_reg - m : a_reg + m;
                2'b01:   a_next = in_val;
                2'b10:   a_next = m;
                default: ;
            endcase
        end
        we = mem_we;
        wa = mem_addr;
        if (mem_we) we_count++;
        @(posedge clk);
        #1;
        a_reg = a_next;
        if (we) mem[wa] = a_old;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench at cycle 0 (START) with reset released.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", ctrl_word(), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        reset = 1'b0;
    endtask

    task automatic clear_mem(input logic [DW-1:0] fill);
        for (int i = 0; i < MEM_N; i++) mem[i] = fill;
    endtask

    // Instruction-set level reference: one whole instruction per call.
    task automatic ref_exec(input logic [DW-1:0] inp, output logic [2:0] op, output logic [AW-1:0] ad);
        logic [DW-1:0] instr;
        instr  = ref_mem[ref_pc];
        op     = instr[7:5];
        ad     = instr[4:0];
        ref_pc = ref_pc + AW'(1);
        case (op)
            3'd0: ref_a = ref_mem[ad];
            3'd1: ref_mem[ad] = ref_a;
            3'd2: ref_a = ref_a + ref_mem[ad];
            3'd3: ref_a = ref_a - ref_mem[ad];
            3'd4: ref_a = inp;
            3'd5: if (ref_a == 8'd0) ref_pc = ad;
            3'd6: if ($signed(ref_a) > $signed(8'sd0)) ref_pc = ad;
            default: ;
        endcase
    endtask

    initial begin
        logic [2:0]    op;
        logic [AW-1:0] ad;
        int            delay;

        n_checks   = 0;
        n_errors   = 0;
        we_count   = 0;
        reset      = 1'b1;
        enter      = 1'b0;
        step       = 1'b1;
        flag_force = 1'b0;
        force_eq0  = 1'b0;
        force_pos  = 1'b0;
        in_val     = 8'd0;
        a_reg      = 8'd0;
        clear_mem(8'h00);

        // Reset and first fetch
        do_reset();
        tick();
        check("c1_ctrl", ctrl_word(), 32'd0);
        ticks(2);
        check("c3_pc", 32'(pc), 32'd1);

        // LOAD 31 then ADD 30
        clear_mem(8'h00);
        mem[0] = 8'h1F; mem[1] = 8'h5E; mem[30] = 8'd3; mem[31] = 8'd5;
        do_reset();
        ticks(3);
        check("load_ctrl", ctrl_word(), 32'({5'd31, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0}));
        ticks(3);
        check("add_ctrl", ctrl_word(), 32'({5'd30, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0}));
        tick();
        check("add_a", 32'(a_reg), 32'd8);

        // SUB to zero then JZ 10, taken and forced not-taken
        clear_mem(8'h00);
        mem[0] = 8'h1F; mem[1] = 8'h7F; mem[2] = 8'hAA; mem[31] = 8'd5;
        do_reset();
        ticks(6);
        check("sub_ctrl", ctrl_word(), 32'({5'd31, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0}));
        ticks(4);
        check("jz_a", 32'(a_reg), 32'd0);
        check("jz_taken_pc", 32'(pc), 32'd10);
        flag_force = 1'b1;
        force_eq0  = 1'b0;
        do_reset();
        ticks(10);
        check("jz_not_taken_pc", 32'(pc), 32'd3);
        flag_force = 1'b0;

        // JPOS: positive taken, negative (signed) not taken
        clear_mem(8'h00);
        mem[0] = 8'h1F; mem[1] = 8'hD4; mem[31] = 8'd5;
        do_reset();
        ticks(7);
        check("jpos_taken_pc", 32'(pc), 32'd20);
        mem[31] = 8'h85;
        do_reset();
        ticks(7);
        check("jpos_neg_pc", 32'(pc), 32'd2);

        // IN handshake: 5 wait cycles, then enter already high on entry
        clear_mem(8'h00);
        mem[0] = 8'h80; mem[1] = 8'h80;
        in_val = 8'hC3;
        do_reset();
        ticks(3);
        for (int w = 0; w < 5; w++) begin
            check("in_wait_ctrl", ctrl_word(), 32'({5'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0}));
            check("in_wait_pc", 32'(pc), 32'd1);
            tick();
        end
        enter = 1'b1;
        #1;
        check("in_load_ctrl", ctrl_word(), 32'({5'd0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0}));
        tick();
        enter = 1'b0;
        #1;
        check("in_fetch_ctrl", ctrl_word(), 32'({5'd1, 7'd0}));
        check("in_a", 32'(a_reg), 32'hC3);
        in_val = 8'h3C;
        enter  = 1'b1;
        tick();
        check("in_decode_ignore", 32'(Aload), 32'd0);
        tick();
        check("in_early_load", 32'(Aload), 32'd1);
        tick();
        enter = 1'b0;
        check("in_early_pc", 32'(pc), 32'd2);
        check("in_early_a", 32'(a_reg), 32'h3C);

        // STORE 28 then HALT
        clear_mem(8'h00);
        mem[0] = 8'h3C; mem[1] = 8'hE0;
        a_reg  = 8'h5A;
        do_reset();
        we_count = 0;
        ticks(3);
        check("store_ctrl", ctrl_word(), 32'({5'd28, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}));
        ticks(3);
        for (int h = 0; h < 20; h++) begin
            check("halt_hold", 32'({halt, Outen}), 32'd3);
            tick();
        end
        check("store_we_count", 32'(we_count), 32'd1);
        check("store_mem", 32'(mem[28]), 32'h5A);
        do_reset();
        check("halt_cleared", 32'(halt), 32'd0);

        // PC wrap through 32 untaken JPOS, then jump-to-self
        clear_mem(8'hC0);
        a_reg = 8'd0;
        do_reset();
        tick();
        for (int i = 0; i < 32; i++) begin
            check("wrap_pc", 32'(pc), 32'(i));
            ticks(3);
        end
        check("wrap_end_pc", 32'(pc), 32'd0);
        mem[0] = 8'hA0;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            ticks(3);
            check("self_jump_pc", 32'(pc), 32'd0);
        end

        // Random programs against the instruction-level model
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < MEM_N; i++) begin
                op = 3'($urandom_range(0, 7));
                if (op == 3'd7 && $urandom_range(0, 5) != 0) op = 3'd2;
                mem[i]     = {op, 5'($urandom)};
                ref_mem[i] = mem[i];
            end
            a_reg  = 8'($urandom);
            ref_a  = a_reg;
            ref_pc = '0;
            enter  = 1'b0;
            do_reset();
            tick();
            for (int k = 0; k < 40; k++) begin
                check("rnd_pc", 32'(pc), 32'(ref_pc));
                check("rnd_a", 32'(a_reg), 32'(ref_a));
                check("rnd_fetch", ctrl_word(), 32'({ref_pc, 7'd0}));
                in_val = 8'($urandom);
                ref_exec(in_val, op, ad);
                if (op == 3'd4) begin
                    delay = $urandom_range(0, 3);
                    ticks(2 + delay);
                    enter = 1'b1;
                    tick();
                    enter = 1'b0;
                end else if (op == 3'd7) begin
                    ticks(2);
                    check("rnd_halt", 32'({halt, Outen}), 32'd3);
                    break;
                end else begin
                    enter = 1'($urandom_range(0, 1));
                    ticks(3);
                    enter = 1'b0;
                    if (op == 3'd1) check("rnd_store", 32'(mem[ad]), 32'(ref_mem[ad]));
                end
            end
        end

`ifdef ACC_CTRL_STEP_EN
        // Single-step: FETCH holds while step is low
        clear_mem(8'h00);
        step = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("step_hold_pc", 32'(pc), 32'd0);
            check("step_hold_ctrl", ctrl_word(), 32'd0);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        ticks(7);
        check("step_one_pc", 32'(pc), 32'd1);
        step = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
